video_timing_ctrl: RTL
======================

# video_timing_ctrl

Parametrised single-clock video timing controller for the display path. It generates HS/VS/BLANK with programmable porches and sync polarity, plus active-area pixel coordinates and frame/line markers. It drives the read strobe of the show-ahead pixel FIFO that feeds RGB and flags FIFO underflow. Frames start only when the pixel source reports ready, and stop cleanly at a frame boundary.

## Interface
Parameters:
- HDISP, 800, active pixels per line
- HFP, 40, horizontal front porch (cycles)
- HPULSE, 48, horizontal sync width
- HBP, 40, horizontal back porch
- VDISP, 480, active lines per frame
- VFP, 13, vertical front porch (lines)
- VPULSE, 3, vertical sync width
- VBP, 29, vertical back porch
- HS_POL, 0, asserted level of HS (0 = active-low)
- VS_POL, 0, asserted level of VS
- FRAME_W, 16, frame counter width

Derived values:
- HTOTAL = HFP+HPULSE+HBP+HDISP
- VTOTAL = VFP+VPULSE+VBP+VDISP
- HOFF = HFP+HPULSE+HBP
- VOFF = VFP+VPULSE+VBP

Ports:
- pixel_clk, in, 1, pixel clock; the only clock
- pixel_rst, in, 1, asynchronous active-high reset
- en, in, 1, run request
- src_ready, in, 1, pixel source primed (FIFO filled)
- fifo_empty, in, 1, pixel FIFO empty
- clr_underflow, in, 1, clears the underflow flag
- HS, out, 1, horizontal sync
- VS, out, 1, vertical sync
- BLANK, out, 1, high during the active area
- rd_en, out, 1, FIFO read strobe
- x, out, $clog2(HDISP), active column
- y, out, $clog2(VDISP), active row
- line_start, out, 1, one-cycle pulse
- frame_start, out, 1, one-cycle pulse
- frame_cnt, out, FRAME_W, completed-frame count
- running, out, 1, high while in RUN
- underflow, out, 1, sticky underflow flag

## Operation
- State machine has two states:
  - IDLE: counters h_cnt and v_cnt held at 0; all outputs at inactive values.
  - RUN: counters advance every cycle.
- IDLE→RUN when en && src_ready are sampled high. In the first RUN cycle the counters are (0,0).
- RUN→IDLE only at the last cycle of a frame (h_cnt==HTOTAL-1, v_cnt==VTOTAL-1) with en low. Deasserting en mid-frame finishes the frame. src_ready is ignored in RUN.
- Counters:
  - h_cnt counts 0..HTOTAL-1 and wraps to 0.
  - v_cnt increments on each h_cnt wrap and wraps to 0 after VTOTAL-1.
  - Widths are $clog2(HTOTAL) and $clog2(VTOTAL).
- Line layout: front porch, sync, back porch, then active. Frame layout uses the same order.
- HS = HS_POL iff HFP ≤ h_cnt < HFP+HPULSE, else ~HS_POL. VS is decoded the same way from v_cnt with VFP, VPULSE and VS_POL.
- BLANK = (h_cnt ≥ HOFF) && (v_cnt ≥ VOFF). rd_en = BLANK. The FIFO is show-ahead, so RGB is the FIFO head while BLANK is high.
- x = h_cnt−HOFF and y = v_cnt−VOFF when BLANK is high, else 0.
- line_start fires at h_cnt==0. frame_start fires at (0,0).
- frame_cnt increments at the end of every completed frame (same condition as the frame-end wrap), modulo 2^FRAME_W. It is not cleared by IDLE.
- underflow is set when rd_en && fifo_empty. It is cleared by clr_underflow; set wins when both happen in the same cycle.
- In IDLE: HS=~HS_POL, VS=~VS_POL, BLANK=rd_en=0, x=y=0, pulses 0.

## Timing
- All outputs are registered and lag the counters by exactly 1 cycle. HS/VS/BLANK/rd_en/x/y/pulses for count (h,v) appear in the cycle after the counters hold (h,v).
- frame_start is therefore 1 cycle after IDLE→RUN (second cycle of RUN).
- running is registered; it rises in the cycle the counters first hold (0,0).
- underflow samples fifo_empty against the registered rd_en, in the same cycle rd_en is high. The flag is visible the next cycle.
- Reset values: state=IDLE, h_cnt=v_cnt=0, HS=~HS_POL, VS=~VS_POL, BLANK=rd_en=0, x=y=0, line_start=frame_start=0, frame_cnt=0, running=0, underflow=0.
- Asserting pixel_rst mid-frame forces reset values immediately (asynchronous). After release, the block re-enters RUN only via en && src_ready.
- Frame period is HTOTAL×VTOTAL cycles; back-to-back frames have no gap.

## Test plan
Small configuration for all scenarios: HDISP=4, HFP=1, HPULSE=2, HBP=1 (HTOTAL=8); VDISP=3, VFP=1, VPULSE=1, VBP=1 (VTOTAL=6).

1. Reset, then en=1, src_ready=1 → frame_start is high 1 cycle after running rises. The frame is 48 cycles. HS is low for 2 cycles per line, starting at line offset 1. VS is low for 8 cycles on line 1. BLANK is high 4 cycles per line on lines 3..5, i.e. 12 cycles per frame.
2. During active lines → x steps 0,1,2,3 per line and y steps 0,1,2. rd_en equals BLANK every cycle. x and y are 0 outside the active area.
3. src_ready=0 with en=1 for 20 cycles, then src_ready=1 → IDLE holds with HS=VS=1. frame_start follows 2 cycles after src_ready rises.
4. Drop en at cycle 10 of a frame → the frame completes all 48 cycles, frame_cnt increments by 1, then IDLE. There is no further frame_start.
5. fifo_empty=1 during an active cycle → underflow is set the next cycle. Asserting clr_underflow together with another empty read keeps it set; a clean clr_underflow clears it.
6. Assert pixel_rst mid-active-line → all outputs go to reset values without waiting for a clock edge. Run HS_POL=1 → HS is high only during its 2 sync cycles. Run FRAME_W=2 → frame_cnt wraps 3→0 after 4 frames.

Source files
------------

// File: rtl/video_timing_ctrl.sv
// Video timing controller for the display path.
// Generates HS/VS/BLANK with programmable porches and sync polarity,
// active-area pixel coordinates and line/frame markers, and drives the read
// strobe of the show-ahead pixel FIFO. All outputs are registered and lag the
// h/v counters by one cycle. Frames start only once the pixel source is
// primed and always stop on a frame boundary.
module video_timing_ctrl #(
    parameter int HDISP   = 800,
    parameter int HFP     = 40,
    parameter int HPULSE  = 48,
    parameter int HBP     = 40,
    parameter int VDISP   = 480,
    parameter int VFP     = 13,
    parameter int VPULSE  = 3,
    parameter int VBP     = 29,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int FRAME_W = 16
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst,
    input  logic                       en,
    input  logic                       src_ready,
    input  logic                       fifo_empty,
    input  logic                       clr_underflow,
    output logic                       HS,
    output logic                       VS,
    output logic                       BLANK,
    output logic                       rd_en,
    output logic [$clog2(HDISP)-1:0]   x,
    output logic [$clog2(VDISP)-1:0]   y,
    output logic                       line_start,
    output logic                       frame_start,
    output logic [FRAME_W-1:0]         frame_cnt,
    output logic                       running,
    output logic                       underflow
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HOFF   = HFP + HPULSE + HBP;
    localparam int VOFF   = VFP + VPULSE + VBP;

    localparam int HW = $clog2(HTOTAL);
    localparam int VW = $clog2(VTOTAL);
    localparam int XW = $clog2(HDISP);
    localparam int YW = $clog2(VDISP);

    // Counter decode points, sized to the counters they are compared with
    localparam logic [HW-1:0] H_LAST     = HW'(HTOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_ACT_BEG  = HW'(HOFF);
    localparam logic [VW-1:0] V_LAST     = VW'(VTOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_ACT_BEG  = VW'(VOFF);

    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            frame_end;

    // Decoded values for the current counter position, registered next edge
    logic            hs_d;
    logic            vs_d;
    logic            blank_d;
    logic            line_start_d;
    logic            frame_start_d;
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;

    assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);

    // State register
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; blocking here would race other always_ff blocks.
            state <= state_nxt;
        end
    end

    // Next state: start when the source is primed, stop only at frame end
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (which would infer a latch).
        state_nxt = state;
        case (state)
            IDLE:    if (en && src_ready) state_nxt = RUN;
            RUN:     if (frame_end && !en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: inactive levels in IDLE, porch/sync/active decode in RUN
    always_comb begin
        hs_d          = ~HS_ON;
        vs_d          = ~VS_ON;
        blank_d       = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        x_d           = '0;
        y_d           = '0;
        if (state == RUN) begin
            hs_d          = (h_cnt >= H_SYNC_BEG && h_cnt < H_SYNC_END) ? HS_ON : ~HS_ON;
            vs_d          = (v_cnt >= V_SYNC_BEG && v_cnt < V_SYNC_END) ? VS_ON : ~VS_ON;
            blank_d       = (h_cnt >= H_ACT_BEG) && (v_cnt >= V_ACT_BEG);
            line_start_d  = (h_cnt == '0);
            frame_start_d = (h_cnt == '0) && (v_cnt == '0);
            if (blank_d) begin
                x_d = XW'(h_cnt - H_ACT_BEG);
                y_d = YW'(v_cnt - V_ACT_BEG);
            end
        end
    end

    // Pixel/line counters: advance in RUN, parked at the origin in IDLE
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (state == RUN) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end else begin
            h_cnt <= '0;
            v_cnt <= '0;
        end
    end

    // Registered timing outputs, one cycle behind the counters
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            HS          <= ~HS_ON;
            VS          <= ~VS_ON;
            BLANK       <= 1'b0;
            rd_en       <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            HS          <= hs_d;
            VS          <= vs_d;
            BLANK       <= blank_d;
            rd_en       <= blank_d;
            x           <= x_d;
            y           <= y_d;
            line_start  <= line_start_d;
            frame_start <= frame_start_d;
        end
    end

    // Completed-frame counter; survives IDLE, only reset clears it
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            frame_cnt <= '0;
        end else if (state == RUN && frame_end) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
        end
    end

    // Running flag tracks the state the counters are about to run in
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            running <= 1'b0;
        end else begin
            running <= (state_nxt == RUN);
        end
    end

    // Sticky underflow: a read from an empty FIFO beats a same-cycle clear
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            underflow <= 1'b0;
        end else if (rd_en && fifo_empty) begin
            underflow <= 1'b1;
        end else if (clr_underflow) begin
            underflow <= 1'b0;
        end
    end

endmodule
